// File: rtl/set_bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// set_bit_serializer_pkg
// Shared definitions for the set-bit serializer slice:
//   - state_t      : serializer FSM state (IDLE waits for a vector, SCAN emits)
//   - DEF_DATA_WD  : default input vector width
//   - DEF_IND_WD   : default emitted index width
// -----------------------------------------------------------------------------
package set_bit_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int DEF_DATA_WD = 8;
  localparam int DEF_IND_WD  = $clog2(DEF_DATA_WD);

endpackage : set_bit_serializer_pkg

// File: rtl/set_bit_serializer_chk.sv
// -----------------------------------------------------------------------------
// set_bit_serializer_chk
// Simulation checker for the serializer: the remaining-bits register must
// never be empty while the FSM is emitting indices.
// Ports:
//   i_clk, i_rst_n        clock / asynchronous active-low reset
//   i_scan                FSM is in SCAN
//   i_rem [DATA_WD-1:0]   remaining-bits register
// -----------------------------------------------------------------------------
module set_bit_serializer_chk #(
  parameter int DATA_WD = 8
) (
  input logic               i_clk,
  input logic               i_rst_n,
  input logic               i_scan,
  input logic [DATA_WD-1:0] i_rem
);

  a_rem_nonzero_in_scan : assert property (
    @(posedge i_clk) disable iff (!i_rst_n) i_scan |-> (i_rem != {DATA_WD{1'b0}})
  );

endmodule : set_bit_serializer_chk

// File: rtl/trailing_one_detect.sv
// -----------------------------------------------------------------------------
// trailing_one_detect
// Combinational detector returning the index of the lowest set bit of i_vec.
// An all-zero vector yields index 0; callers qualify the result themselves.
// Ports:
//   i_vec   [DATA_WD-1:0]  vector to examine
//   o_index [IND_WD-1:0]   index of the lowest set bit
// -----------------------------------------------------------------------------
module trailing_one_detect
  import set_bit_serializer_pkg::*;
#(
  parameter int DATA_WD = DEF_DATA_WD,
  parameter int IND_WD  = $clog2(DATA_WD)
) (
  input  logic [DATA_WD-1:0] i_vec,
  output logic [IND_WD-1:0]  o_index
);

  // Priority scan from MSB down so the lowest set bit is the last to win.
  always_comb begin
    o_index = {IND_WD{1'b0}};
    for (int i = DATA_WD - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_index = IND_WD'(i);
      end else begin
        o_index = o_index;
      end
    end
  end

endmodule : trailing_one_detect

// File: rtl/set_bit_serializer.sv
// -----------------------------------------------------------------------------
// set_bit_serializer
// Accepts a DATA_WD-bit vector over valid/ready and emits the index of every
// set bit, lowest first, one index per accepted output beat.
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_valid      upstream vector valid
//   o_ready      block can accept a vector this cycle
//   i_data       vector to serialise
//   o_valid      o_index is valid
//   i_ready      downstream accepts o_index this cycle
//   o_index      index of lowest remaining set bit
//   o_last       this index is the final set bit of the vector
//   o_zero_drop  one-cycle pulse: an all-zero vector was accepted and dropped
//   o_busy       a vector is being serialised
// Note: o_ready depends combinationally on i_ready while in SCAN so the next
// vector can be taken on the same edge as the final index (zero bubble).
// -----------------------------------------------------------------------------
module set_bit_serializer
  import set_bit_serializer_pkg::*;
#(
  parameter int DATA_WD = DEF_DATA_WD,
  parameter int IND_WD  = $clog2(DATA_WD)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_WD-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [IND_WD-1:0]  o_index,
  output logic               o_last,
  output logic               o_zero_drop,
  output logic               o_busy
);

  localparam logic [DATA_WD-1:0] ONE_VEC  = {{(DATA_WD-1){1'b0}}, 1'b1};
  localparam logic [DATA_WD-1:0] ZERO_VEC = {DATA_WD{1'b0}};

  state_t             r_state;
  logic [DATA_WD-1:0] r_rem;
  logic               r_valid;
  logic               r_busy;
  logic               r_zero_drop;

  logic [IND_WD-1:0]  w_index;
  logic               w_single;
  logic               w_last;
  logic               w_ready;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_nonzero;
  logic [DATA_WD-1:0] w_rem_next;

  trailing_one_detect #(
    .DATA_WD (DATA_WD),
    .IND_WD  (IND_WD)
  ) u_tod (
    .i_vec   (r_rem),
    .o_index (w_index)
  );

  // Handshake qualifiers and next remaining-bits value after clearing o_index.
  always_comb begin
    // rem & (rem-1) clears the lowest set bit; zero result means one bit left.
    w_single   = ((r_rem & (r_rem - ONE_VEC)) == ZERO_VEC);
    // Gate with r_valid so o_last reads 0 in IDLE where rem is 0.
    w_last     = r_valid & w_single;
    w_ready    = (r_state == IDLE) | (w_last & i_ready);
    w_in_xfer  = i_valid & w_ready;
    w_out_xfer = r_valid & i_ready;
    w_nonzero  = (i_data != ZERO_VEC);
    w_rem_next = r_rem & ~(ONE_VEC << w_index);
  end

  // Serializer FSM: owns rem, valid/busy flags and the zero-drop pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_rem       <= ZERO_VEC;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_zero_drop <= 1'b0;
    end else begin
      r_zero_drop <= w_in_xfer & ~w_nonzero;
      case (r_state)
        IDLE: begin
          if (w_in_xfer && w_nonzero) begin
            r_rem   <= i_data;
            r_state <= SCAN;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        SCAN: begin
          if (w_out_xfer && w_last) begin
            if (w_in_xfer && w_nonzero) begin
              r_rem   <= i_data;
              r_state <= SCAN;
            end else begin
              r_rem   <= ZERO_VEC;
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
            end
          end else if (w_out_xfer) begin
            r_rem <= w_rem_next;
          end else begin
            r_rem <= r_rem;
          end
        end
        default: begin
          r_state <= IDLE;
          r_rem   <= ZERO_VEC;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready     = w_ready;
  assign o_valid     = r_valid;
  assign o_index     = w_index;
  assign o_last      = w_last;
  assign o_zero_drop = r_zero_drop;
  assign o_busy      = r_busy;

  set_bit_serializer_chk #(
    .DATA_WD (DATA_WD)
  ) u_chk (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_scan  (r_state == SCAN),
    .i_rem   (r_rem)
  );

endmodule : set_bit_serializer
